// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op/state encodings and helpers for the iterative
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter must be able to hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration: shift-add multiply or
//               restoring-divide quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH:0]   i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH:0]   o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;

    always_comb begin
        w_sum   = i_hi + (i_lo[0] ? {1'b0, i_opnd} : '0);
        w_shift = {i_hi[WIDTH-1:0], i_lo[WIDTH-1]};
        w_trial = {1'b0, w_shift} - {2'b00, i_opnd};
        o_hi    = '0;
        o_lo    = '0;
        if (i_div) begin
            // Negative trial result means the divisor did not fit: restore.
            if (w_trial[WIDTH+1]) begin
                o_hi = w_shift;
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end else begin
                o_hi = w_trial[WIDTH:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            o_hi = {1'b0, w_sum[WIDTH:1]};
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative MULT/MULTU/DIV/DIVU unit with start/busy/done
//               handshake and cancel, producing the HI/LO pair.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cancel,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_dbz_pend;
    logic               r_dbz;
    logic [WIDTH:0]     r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_is_div;
    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_b_zero;
    logic               w_skip;
    logic [WIDTH:0]     w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_mag_prod;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && i_start && !i_cancel;
    assign w_is_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
    assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_sa     = w_signed & i_a[WIDTH-1];
    assign w_sb     = w_signed & i_b[WIDTH-1];
    assign w_abs_a  = w_sa ? -i_a : i_a;
    assign w_abs_b  = w_sb ? -i_b : i_b;
    assign w_b_zero = (i_b == '0);
    assign w_skip   = w_is_div ? w_b_zero : FAST_MUL;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_div  (r_is_div),
        .i_hi   (r_acc_hi),
        .i_lo   (r_acc_lo),
        .i_opnd (r_opnd),
        .o_hi   (w_step_hi),
        .o_lo   (w_step_lo)
    );

    generate
        if (FAST_MUL) begin : g_fast_mul
            assign w_mag_prod = {{WIDTH{1'b0}}, r_opnd} * {{WIDTH{1'b0}}, r_acc_lo};
        end else begin : g_iter_mul
            assign w_mag_prod = {r_acc_hi[WIDTH-1:0], r_acc_lo};
        end
    endgenerate

    assign w_prod = (r_sign_a ^ r_sign_b) ? -w_mag_prod : w_mag_prod;

    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_dbz_pend) begin
                // No iterations ran, so the accumulator still holds |a|.
                w_fix_hi = r_sign_a ? -r_acc_lo : r_acc_lo;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = r_sign_a ? -r_acc_hi[WIDTH-1:0] : r_acc_hi[WIDTH-1:0];
                w_fix_lo = (r_sign_a ^ r_sign_b) ? -r_acc_lo : r_acc_lo;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_next = w_skip ? FIX : CALC;
                end else begin
                    w_next = IDLE;
                end
            end
            CALC:    if (r_cnt == CW'(WIDTH - 1)) w_next = FIX;
            FIX:     w_next = DONE;
            default: w_next = IDLE;
        endcase
        if (i_cancel) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_dbz      <= 1'b0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_opnd     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_is_div   <= w_is_div;
            r_sign_a   <= w_sa;
            r_sign_b   <= w_sb;
            r_dbz_pend <= w_is_div & w_b_zero;
            r_dbz      <= 1'b0;
            r_acc_hi   <= '0;
            r_acc_lo   <= w_is_div ? w_abs_a : w_abs_b;
            r_opnd     <= w_is_div ? w_abs_b : w_abs_a;
        end else if (!i_cancel && (r_state == CALC)) begin
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
            r_cnt    <= r_cnt + 1'b1;
        end else if (!i_cancel && (r_state == FIX)) begin
            r_hi  <= w_fix_hi;
            r_lo  <= w_fix_lo;
            r_dbz <= r_dbz_pend;
        end
    end

    assign o_busy        = (r_state == CALC) || (r_state == FIX);
    assign o_done        = (r_state == DONE);
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;
    assign o_div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_iter
// Description : Self-checking bench for both FAST_MUL variants of muldiv_iter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst, start, cancel;
    logic [1:0] op;
    logic [W-1:0] a, b;
    logic [1:0] d_busy, d_done, d_dbz;
    logic [1:0][W-1:0] d_hi, d_lo;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(W), .FAST_MUL(1'b1)) u_fast (
        .clk(clk), .rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
        .i_cancel(cancel), .o_busy(d_busy[0]), .o_done(d_done[0]),
        .o_hi(d_hi[0]), .o_lo(d_lo[0]), .o_div_by_zero(d_dbz[0]));

    muldiv_iter #(.WIDTH(W), .FAST_MUL(1'b0)) u_iter (
        .clk(clk), .rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
        .i_cancel(cancel), .o_busy(d_busy[1]), .o_done(d_done[1]),
        .o_hi(d_hi[1]), .o_lo(d_lo[1]), .o_div_by_zero(d_dbz[1]));

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference for one operation.
    function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rz);
        logic signed [2*W-1:0] sp;
        logic [2*W-1:0] up;
        logic [W-1:0] most_neg;
        most_neg = {1'b1, {(W-1){1'b0}}};
        rz = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin
                sp = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
                {rh, rl} = sp;
            end
            2'b01: begin
                up = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                {rh, rl} = up;
            end
            default: begin
                if (y == '0) begin
                    rh = x; rl = '1; rz = 1'b1;
                end else if (o == 2'b11) begin
                    rl = x / y; rh = x % y;
                end else if (x == most_neg && y == '1) begin
                    rl = most_neg; rh = '0;
                end else begin
                    rl = W'($signed(x) / $signed(y));
                    rh = W'($signed(x) % $signed(y));
                end
            end
        endcase
    endfunction

    // Timing/result model: busy cycles remaining per instance (0 = fast, 1 = iterative).
    int m_left[2];
    logic m_done[2], m_dbz[2], p_dbz[2];
    logic [W-1:0] m_hi[2], m_lo[2], p_hi[2], p_lo[2];

    always @(posedge clk) begin
        logic [W-1:0] th, tl;
        logic tz;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_left[k] <= 0; m_done[k] <= 1'b0;
                m_hi[k] <= '0; m_lo[k] <= '0; m_dbz[k] <= 1'b0;
            end else if (cancel) begin
                m_left[k] <= 0; m_done[k] <= 1'b0;
            end else if (m_left[k] > 0) begin
                m_left[k] <= m_left[k] - 1;
                if (m_left[k] == 1) begin
                    m_done[k] <= 1'b1;
                    m_hi[k] <= p_hi[k]; m_lo[k] <= p_lo[k]; m_dbz[k] <= p_dbz[k];
                end
            end else begin
                m_done[k] <= 1'b0;
                if (start) begin
                    ref_op(op, a, b, th, tl, tz);
                    p_hi[k] <= th; p_lo[k] <= tl; p_dbz[k] <= tz;
                    m_dbz[k] <= 1'b0;
                    m_left[k] <= ((op[1] ? (b == '0) : (k == 0)) ? 1 : W + 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy[%0d]", k), W'(d_busy[k]), W'(m_left[k] > 0));
                chk($sformatf("done[%0d]", k), W'(d_done[k]), W'(m_done[k]));
                chk($sformatf("dbz[%0d]", k),  W'(d_dbz[k]),  W'(m_dbz[k]));
                chk($sformatf("hi[%0d]", k),   d_hi[k], m_hi[k]);
                chk($sformatf("lo[%0d]", k),   d_lo[k], m_lo[k]);
            end
        end
    end

    // Issue one op from idle, measure done latency for each instance, check literal results.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez,
                          input int lat0, input int lat1);
        int seen[2];
        seen[0] = 0; seen[1] = 0;
        op = o; a = x; b = y; start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 2; k++)
                if (d_done[k] && seen[k] == 0) seen[k] = n;
        end
        chk({nm, " lat fast"}, W'(seen[0]), W'(lat0));
        chk({nm, " lat iter"}, W'(seen[1]), W'(lat1));
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s hi[%0d]", nm, k), d_hi[k], eh);
            chk($sformatf("%s lo[%0d]", nm, k), d_lo[k], el);
            chk($sformatf("%s dbz[%0d]", nm, k), W'(d_dbz[k]), W'(ez));
        end
    endtask

    initial begin
        logic [W-1:0] prev_hi, prev_lo;
        int sel;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset hi", d_hi[1], '0);
        chk("reset busy", W'(d_busy), '0);
        rst = 1'b0;
        @(negedge clk);

        run_op("multu_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 2, 34);
        run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 2, 34);
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 34);
        run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 34);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34, 34);
        run_op("divu_zero", 2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1, 2, 2);

        // Next accepted start clears the divide-by-zero flag.
        op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("dbz cleared", W'(d_dbz), '0);
        repeat (40) @(negedge clk);

        // Ignored start while busy, then cancel mid-operation.
        prev_hi = d_hi[1]; prev_lo = d_lo[1];
        op = 2'b11; a = 32'd50000; b = 32'd9; start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = (n == 5);
            if (n == 5) begin op = 2'b00; a = 32'd5; b = 32'd6; end
            cancel = (n == 10);
        end
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        chk("cancel busy", W'(d_busy), '0);
        chk("cancel done", W'(d_done), '0);
        chk("cancel hi", d_hi[1], prev_hi);
        chk("cancel lo", d_lo[1], prev_lo);
        repeat (40) @(negedge clk);

        // start and cancel together: nothing begins.
        op = 2'b11; a = 32'd77; b = 32'd5; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("start+cancel busy", W'(d_busy), '0);
        repeat (3) @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst    = ($urandom_range(0, 599) == 0);
            start  = ($urandom_range(0, 2) == 0);
            cancel = ($urandom_range(0, 59) == 0);
            op     = 2'($urandom_range(0, 3));
            sel    = $urandom_range(0, 7);
            a      = $urandom;
            b      = $urandom;
            if (sel == 0) b = '0;
            if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if (sel == 2) begin a = W'($urandom_range(0, 300)); b = W'($urandom_range(1, 20)); end
            if (sel == 3) b = -W'($urandom_range(1, 20));
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0; cancel = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
